// File: rtl/edge_packer.sv
// Edge packer: thresholds Sobel gradients into edge bits, packs them LSB-first into bytes, and buffers the bytes in a small FIFO.
// Optional macro EDGE_COUNT_EN enables a per-frame saturating edge counter on edge_count.
module edge_packer #(
  parameter int GRAD_WIDTH = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [GRAD_WIDTH-1:0]         gradient,
  input  logic                          gradient_valid,
  input  logic [GRAD_WIDTH-1:0]         threshold,
  input  logic                          flush,
  output logic [7:0]                    edge_byte,
  output logic                          edge_valid,
  input  logic                          edge_ready,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   edge_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          edge_bit;
  logic [7:0]    pack_data;
  logic          push;
  logic          pop;
  logic          full;
  logic          do_write;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [7:0]    mem [FIFO_DEPTH];

  // Edge decision and the byte as it would look including this cycle's sample
  always_comb begin
    edge_bit  = gradient >= threshold;
    pack_data = shreg;
    if (gradient_valid)
      pack_data = shreg | (8'(edge_bit) << bit_cnt);
  end

  // A byte leaves the packer when full or when a frame ends with bits pending
  assign push = (gradient_valid && bit_cnt == 3'd7)
             || (flush && (gradient_valid || bit_cnt != 3'd0));

  assign edge_valid = fifo_level != '0;
  assign edge_byte  = mem[rd_ptr];
  assign pop        = edge_valid && edge_ready;
  assign full       = fifo_level == LW'(FIFO_DEPTH);
  // At full, a same-cycle pop frees the slot the new byte needs
  assign do_write   = push && (!full || pop);

  // Bit packing register and position counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (push) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (gradient_valid) begin
      bit_cnt <= bit_cnt + 3'd1;
      shreg   <= pack_data;
    end
  end

  // Byte FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_write) begin
        mem[wr_ptr] <= pack_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + LW'(do_write) - LW'(pop);
      if (push && !do_write)
        overflow <= 1'b1;
    end
  end

`ifdef EDGE_COUNT_EN
  logic [15:0] acc;
  logic        cnt_inc;

  assign cnt_inc = gradient_valid && edge_bit;

  // Saturating per-frame edge accumulator, published on flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc        <= '0;
      edge_count <= '0;
    end else if (flush) begin
      acc        <= '0;
      edge_count <= (cnt_inc && acc != 16'hFFFF) ? acc + 16'd1 : acc;
    end else if (cnt_inc && acc != 16'hFFFF) begin
      acc <= acc + 16'd1;
    end
  end
`else
  assign edge_count = '0;
`endif

endmodule

// File: doc/edge_packer.md
EDGE_PACKER -- requirements
Module: edge_packer

Interface
REQ-001 SHALL have parameter GRAD_WIDTH, default 11: width of the gradient magnitude input.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: number of output byte slots, power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port gradient, input, GRAD_WIDTH: unsigned gradient magnitude from the Sobel stage.
REQ-006 SHALL have port gradient_valid, input, 1: gradient is sampled when this is high.
REQ-007 SHALL have port threshold, input, GRAD_WIDTH: unsigned edge threshold, sampled on every valid cycle.
REQ-008 SHALL have port flush, input, 1: single-cycle end-of-frame pulse.
REQ-009 SHALL have port edge_byte, output, 8: FIFO head, holding 8 packed edge bits.
REQ-010 SHALL have port edge_valid, output, 1: FIFO not empty.
REQ-011 SHALL have port edge_ready, input, 1: downstream accepts edge_byte.
REQ-012 SHALL have port overflow, output, 1: sticky flag, set when a byte was dropped.
REQ-013 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1: current occupancy.
REQ-014 SHALL have port edge_count, output, 16: edge total of the last flushed frame (EDGE_COUNT_EN only).

Function
REQ-015 SHALL compute the edge bit as 1 when gradient >= threshold (unsigned), otherwise 0, only on cycles where gradient_valid=1.
REQ-016 SHALL pack edge bits LSB-first: the first valid sample after reset or after a flush goes to bit0; bit_cnt counts 0..7.
REQ-017 SHALL push the assembled byte into the FIFO on the same edge that captures the 8th bit, then wrap bit_cnt to 0.
REQ-018 SHALL, on flush=1 with bit_cnt!=0, push the partial byte with its unfilled upper bits set to 0, then clear bit_cnt.
REQ-019 SHALL, on flush=1 together with gradient_valid=1, include that sample in the byte before the flush push; if that sample completes 8 bits, exactly one byte is pushed.
REQ-020 SHALL push nothing on flush=1 when bit_cnt=0 and gradient_valid=0.
REQ-021 SHALL drive edge_valid high from the cycle after a push into an empty FIFO; latency from the capture edge of the 8th bit to edge_valid is 1 cycle.
REQ-022 SHALL pop the head on a rising edge where edge_valid=1 and edge_ready=1; edge_byte SHALL hold stable while edge_valid=1 and edge_ready=0.
REQ-023 SHALL, on a push when fifo_level=FIFO_DEPTH and no pop occurs in the same cycle, drop the new byte, leave FIFO contents unchanged, and set overflow.
REQ-024 SHALL accept a simultaneous push and pop at full without overflow; fifo_level stays unchanged.
REQ-025 SHALL accept a simultaneous push and pop at empty only as a push, because edge_valid=0 blocks the pop.
REQ-026 SHALL use wrapping read and write pointers modulo FIFO_DEPTH; fifo_level SHALL always equal pushes minus pops.
REQ-027 SHALL keep overflow set until reset.

Reset
REQ-028 SHALL, while rst=0 regardless of clk, set bit_cnt=0, the packing register to 0, both pointers to 0, fifo_level=0, edge_valid=0, edge_byte=0, overflow=0, and edge_count=0.
REQ-029 SHALL discard a partially packed byte and all FIFO contents on reset asserted mid-frame; the first sample after release goes to bit0.

Configuration
REQ-030 SHALL, with macro EDGE_COUNT_EN defined, count edge bits in a 16-bit accumulator that saturates at 0xFFFF.
REQ-031 SHALL, with EDGE_COUNT_EN defined, latch the accumulator plus any same-cycle edge bit into edge_count on flush, then restart the accumulator at 0.
REQ-032 SHALL, without EDGE_COUNT_EN, omit the accumulator and drive edge_count constant 0.

Verification
REQ-033 SHALL cover threshold=100 with gradients 100,99,200,0,150,1,101,100 and edge_ready=1 -> one byte 0xD5, edge_valid high for exactly 1 cycle.
REQ-034 SHALL cover threshold=0 with 3 valid samples, then flush -> byte 0x07, and edge_count=3 when EDGE_COUNT_EN is defined.
REQ-035 SHALL cover edge_ready=0 with 40 samples all above threshold -> fifo_level=4, overflow=1, then draining returns exactly 4 bytes of 0xFF.
REQ-036 SHALL cover FIFO full with a pop and a push in the same cycle -> overflow stays 0 and fifo_level stays 4.
REQ-037 SHALL cover the 8th sample arriving with flush=1 -> exactly one byte pushed and bit_cnt=0.
REQ-038 SHALL cover rst=0 asserted between clock edges after 5 samples -> outputs 0 immediately, and the next 8 samples produce a full, correctly aligned byte.
